truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Upstream stimulus source and downstream result checker for a 4-input, 1-output gate-level circuit under test (CUT).
- On `start`, drives all 16 input vectors in ascending order and waits a fixed settle time per vector.
- Samples the CUT output into a 16-bit truth table and compares it against an expected table.
- Sits between the lab top-level control (button/testbench) and the combinational CUT.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..15.
- EXPECTED, 16'hFFFF, expected truth table; bit i = required `s` for vector i.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  sweep request; sampled only in IDLE.
- vec  output  4  CUT stimulus: vec[3]=a, vec[2]=b, vec[1]=c, vec[0]=d.
- s_in  input  1  CUT output, synchronous to clk via CUT; no synchroniser.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- done  output  1  single-cycle pulse when the sweep completes.
- pass  output  1  1 when the captured table equals EXPECTED; valid from done, held until next accepted start.
- table_out  output  16  captured truth table; bit i = s_in sampled for vector i.

Behaviour:
- Reset, asynchronous: state=IDLE, vec=0, settle count=0, busy=0, done=0, pass=0, table_out=0.
- States:
  - IDLE: start=1 → DRIVE; vec=0, count=0, table_out=0, pass=0.
  - DRIVE: holds vec; count increments each cycle. When count==SETTLE_CYCLES-1 → SAMPLE.
  - SAMPLE: one cycle. table_out[vec] <= s_in.
    - vec==15 → DONE.
    - Otherwise vec <= vec+1, count <= 0, → DRIVE.
  - DONE: one cycle. done=1; pass <= (captured table == EXPECTED), with bit 15 included from the SAMPLE just completed. → IDLE.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - done is high in cycle 16*(SETTLE_CYCLES+1)+1 after the start-sampling edge (49 for default).
- start while busy: ignored, with no restart or queueing. start held high through DONE→IDLE: a new sweep begins on the next IDLE edge.
- vec wraps only by explicit reset to 0 at start. vec stays 15 after completion until the next start.
- table_out and pass are stable in IDLE. Neither is modified mid-sweep except table_out bit updates in SAMPLE and the clear at start.
- Reset mid-sweep: immediate return to reset values; no done pulse.
- All outputs are registered.

Optional Feature:
- Macro: SWEEP_FAIL_CAPTURE_EN.
- Defined: adds outputs fail_cnt[4:0], first_fail[3:0] and first_fail_vld.
  - In each SAMPLE where s_in != EXPECTED[vec], fail_cnt increments.
  - On the first mismatch of the sweep, first_fail <= vec and first_fail_vld <= 1.
  - All three clear at reset and on accepted start. fail_cnt saturates at 16 by construction.
- Undefined: these ports and their logic are absent. Pass/fail reporting is table compare only.

Decomposition:
- Shared package (sweep_pkg): VEC_W=4, N_VEC=16, CNT_W=4, and state encoding constants IDLE/DRIVE/SAMPLE/DONE (2-bit).
- One sub-module: sweep_settle_cnt. It is a loadable up-counter with clear and terminal-count flag (count==SETTLE_CYCLES-1), instantiated by the FSM.

Test Plan:
- Reset then start pulse, s_in tied 1, default params → vec steps 0..15, each held 3 cycles; done at cycle 49; table_out=16'hFFFF; pass=1.
- s_in driven as vec[0] (ideal d buffer), EXPECTED=16'hAAAA → table_out=16'hAAAA, pass=1. Repeat with EXPECTED=16'hFFFF → pass=0.
- start pulsed again at cycle 20 of a sweep → ignored; single done at cycle 49; busy continuous.
- rst_n low at cycle 25 → vec=0, busy=0, table_out=0 immediately; no done. Fresh start then completes normally.
- SETTLE_CYCLES=1 → per-vector period 2 cycles; done at cycle 33.
- With SWEEP_FAIL_CAPTURE_EN, s_in=1 except 0 at vec 5 and 9, EXPECTED=16'hFFFF → fail_cnt=2, first_fail=5, first_fail_vld=1, pass=0.

Source files
------------

// File: rtl/sweep_pkg.sv
// ---------------------------------------------------------------------------
// sweep_pkg
// Shared constants for the truth-table sweeper: vector/counter widths, the
// number of input vectors, and the 2-bit FSM state encoding. The FSM states
// are plain localparams so the encoding stays readable in older tools.
// Ports: none (package).
// ---------------------------------------------------------------------------
package sweep_pkg;

    localparam int VEC_W = 4;
    localparam int N_VEC = 16;
    localparam int CNT_W = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRIVE  = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // Returns the table with one bit replaced; keeps the indexed write in
    // one place for readers of the FSM.
    function automatic logic [N_VEC-1:0] put_bit(
        input logic [N_VEC-1:0] tbl,
        input logic [VEC_W-1:0] idx,
        input logic             val
    );
        logic [N_VEC-1:0] r;
        r      = tbl;
        r[idx] = val;
        return r;
    endfunction

endpackage

// File: rtl/sweep_settle_cnt.sv
// ---------------------------------------------------------------------------
// sweep_settle_cnt
// Loadable up-counter that measures how long each vector has been held.
// Clear has priority over load, and load has priority over increment.
// tc flags the last settle cycle (count == SETTLE_CYCLES-1).
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   clr          force count to zero
//   load         load count from load_val
//   load_val     value to load
//   en           increment count
//   tc           terminal-count flag
// ---------------------------------------------------------------------------
module sweep_settle_cnt
    import sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper
// Drives all 16 input vectors of a 4-input combinational circuit in
// ascending order, holds each for SETTLE_CYCLES cycles, samples the circuit
// output into a 16-bit truth table and compares the table with EXPECTED.
// Optional feature macro: SWEEP_FAIL_CAPTURE_EN (adds per-vector mismatch
// count and first failing vector).
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   start           sweep request, honoured only in IDLE
//   vec             circuit stimulus {a,b,c,d}
//   s_in            circuit output
//   busy            sweep in progress (through the DONE cycle)
//   done            one-cycle completion pulse
//   pass            captured table equals EXPECTED
//   table_out       captured truth table, bit i = response to vector i
//   fail_cnt        (feature) number of mismatching vectors this sweep
//   first_fail      (feature) first mismatching vector
//   first_fail_vld  (feature) first_fail holds a real vector
// ---------------------------------------------------------------------------
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int               SETTLE_CYCLES = 2,
    parameter logic [N_VEC-1:0] EXPECTED      = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [VEC_W-1:0] vec,
    input  logic             s_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_VEC-1:0] table_out
`ifdef SWEEP_FAIL_CAPTURE_EN
    ,
    output logic [4:0]       fail_cnt,
    output logic [VEC_W-1:0] first_fail,
    output logic             first_fail_vld
`endif
);

    logic [1:0]       state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [N_VEC-1:0] table_q, table_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;

`ifdef SWEEP_FAIL_CAPTURE_EN
    logic [4:0]       fail_cnt_q, fail_cnt_d;
    logic [VEC_W-1:0] first_fail_q, first_fail_d;
    logic             first_fail_vld_q, first_fail_vld_d;
`endif

    sweep_settle_cnt #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load     (1'b0),
        .load_val ({CNT_W{1'b0}}),
        .en       (cnt_en),
        .tc       (cnt_tc)
    );

    // Sweep sequencing. pass is computed on the edge that enters DONE, using
    // the table that already includes vector 15, so it is valid in the same
    // cycle as the done pulse.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        table_d = table_q;
        pass_d  = pass_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
`ifdef SWEEP_FAIL_CAPTURE_EN
        fail_cnt_d       = fail_cnt_q;
        first_fail_d     = first_fail_q;
        first_fail_vld_d = first_fail_vld_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    vec_d   = '0;
                    table_d = '0;
                    pass_d  = 1'b0;
                    cnt_clr = 1'b1;
`ifdef SWEEP_FAIL_CAPTURE_EN
                    fail_cnt_d       = '0;
                    first_fail_d     = '0;
                    first_fail_vld_d = 1'b0;
`endif
                end
            end
            DRIVE: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    state_d = SAMPLE;
                    cnt_clr = 1'b1;
                end
            end
            SAMPLE: begin
                table_d = put_bit(table_q, vec_q, s_in);
`ifdef SWEEP_FAIL_CAPTURE_EN
                if (s_in != EXPECTED[vec_q]) begin
                    fail_cnt_d = fail_cnt_q + 5'd1;
                    if (!first_fail_vld_q) begin
                        first_fail_d     = vec_q;
                        first_fail_vld_d = 1'b1;
                    end
                end
`endif
                if (vec_q == VEC_W'(N_VEC - 1)) begin
                    state_d = DONE;
                    pass_d  = (table_d == EXPECTED);
                end else begin
                    vec_d   = vec_q + VEC_W'(1);
                    state_d = DRIVE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            table_q <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            table_q <= table_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef SWEEP_FAIL_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt_q       <= '0;
            first_fail_q     <= '0;
            first_fail_vld_q <= 1'b0;
        end else begin
            fail_cnt_q       <= fail_cnt_d;
            first_fail_q     <= first_fail_d;
            first_fail_vld_q <= first_fail_vld_d;
        end
    end

    assign fail_cnt       = fail_cnt_q;
    assign first_fail     = first_fail_q;
    assign first_fail_vld = first_fail_vld_q;
`endif

    assign vec       = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign table_out = table_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// tb_truth_table_sweeper
// Directed bench for truth_table_sweeper. Three instances share clock and
// reset: dut 0 (defaults, selectable CUT model), dut 1 (EXPECTED=16'hAAAA,
// CUT is an ideal d buffer) and dut 2 (SETTLE_CYCLES=1, CUT output tied 1).
// ---------------------------------------------------------------------------
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1, start2;
    logic        s0, s1, s2;
    logic [3:0]  vec0, vec1, vec2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic        pass0, pass1, pass2;
    logic [15:0] tbl0, tbl1, tbl2;
    int          s0_mode;
    int          n_cmp = 0;
    int          n_err = 0;

`ifdef SWEEP_FAIL_CAPTURE_EN
    logic [4:0] fc0, fc1, fc2;
    logic [3:0] ff0, ff1, ff2;
    logic       fv0, fv1, fv2;
`endif

    always #5 clk = ~clk;

    // CUT models: 0 = output tied 1, 1 = ideal d buffer, 2 = 1 except
    // vectors 5 and 9.
    always_comb begin
        s0 = 1'b1;
        if (s0_mode == 1) begin
            s0 = vec0[0];
        end else if (s0_mode == 2) begin
            s0 = (vec0 != 4'd5) && (vec0 != 4'd9);
        end
    end
    assign s1 = vec1[0];
    assign s2 = 1'b1;

    truth_table_sweeper u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .vec(vec0), .s_in(s0),
        .busy(busy0), .done(done0), .pass(pass0), .table_out(tbl0)
`ifdef SWEEP_FAIL_CAPTURE_EN
        , .fail_cnt(fc0), .first_fail(ff0), .first_fail_vld(fv0)
`endif
    );

    truth_table_sweeper #(.SETTLE_CYCLES(2), .EXPECTED(16'hAAAA)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .vec(vec1), .s_in(s1),
        .busy(busy1), .done(done1), .pass(pass1), .table_out(tbl1)
`ifdef SWEEP_FAIL_CAPTURE_EN
        , .fail_cnt(fc1), .first_fail(ff1), .first_fail_vld(fv1)
`endif
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .vec(vec2), .s_in(s2),
        .busy(busy2), .done(done2), .pass(pass2), .table_out(tbl2)
`ifdef SWEEP_FAIL_CAPTURE_EN
        , .fail_cnt(fc2), .first_fail(ff2), .first_fail_vld(fv2)
`endif
    );

    function automatic logic get_done(input int idx);
        return (idx == 0) ? done0 : (idx == 1) ? done1 : done2;
    endfunction

    function automatic logic get_busy(input int idx);
        return (idx == 0) ? busy0 : (idx == 1) ? busy1 : busy2;
    endfunction

    function automatic logic get_pass(input int idx);
        return (idx == 0) ? pass0 : (idx == 1) ? pass1 : pass2;
    endfunction

    function automatic logic [3:0] get_vec(input int idx);
        return (idx == 0) ? vec0 : (idx == 1) ? vec1 : vec2;
    endfunction

    function automatic logic [15:0] get_table(input int idx);
        return (idx == 0) ? tbl0 : (idx == 1) ? tbl1 : tbl2;
    endfunction

    task automatic set_start(input int idx, input logic val);
        if (idx == 0) start0 = val;
        else if (idx == 1) start1 = val;
        else start2 = val;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses start for one cycle, then watches 80 cycles. Cycle 1 is the
    // cycle after the start-sampling edge. A second start pulse is issued
    // at cycle restart_at (0 = none). Vector expectation: vector k is on
    // vec for cycles k*(settle+1)+1 .. (k+1)*(settle+1); vec stays 15 after.
    task automatic apply_stimulus(input int idx, input int restart_at,
                                  input int settle, input int last_cyc,
                                  output int done_cyc, output int done_cnt,
                                  output int busy_bad, output int vec_bad,
                                  output logic pass_at_done,
                                  output int clr_bad);
        int exp_vec;
        done_cyc     = 0;
        done_cnt     = 0;
        busy_bad     = 0;
        vec_bad      = 0;
        clr_bad      = 0;
        pass_at_done = 1'b0;
        @(negedge clk);
        set_start(idx, 1'b1);
        @(negedge clk);
        set_start(idx, 1'b0);
        if (get_table(idx) !== 16'h0 || get_pass(idx) !== 1'b0) clr_bad = 1;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (get_done(idx) === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc     = cyc;
                    pass_at_done = get_pass(idx);
                end
            end
            if (get_busy(idx) !== (cyc <= last_cyc)) busy_bad++;
            exp_vec = (cyc >= last_cyc) ? 15 : (cyc - 1) / (settle + 1);
            if (get_vec(idx) !== 4'(exp_vec)) vec_bad++;
            set_start(idx, (cyc == restart_at));
            @(negedge clk);
        end
        set_start(idx, 1'b0);
    endtask

    int   dc, dn, bb, vb, cb;
    logic pd;

    initial begin
        rst_n   = 1'b0;
        start0  = 1'b0;
        start1  = 1'b0;
        start2  = 1'b0;
        s0_mode = 0;
        repeat (3) @(negedge clk);

        // Reset values
        check_output("rst_vec", 32'(vec0), 32'h0);
        check_output("rst_busy", 32'(busy0), 32'h0);
        check_output("rst_done", 32'(done0), 32'h0);
        check_output("rst_pass", 32'(pass0), 32'h0);
        check_output("rst_table", 32'(tbl0), 32'h0);
        rst_n = 1'b1;

        // Sweep with CUT output tied 1
        $display("[TB] sweep, s_in=1");
        apply_stimulus(0, 0, 2, 49, dc, dn, bb, vb, pd, cb);
        check_output("ones_done_cyc", 32'(dc), 32'd49);
        check_output("ones_done_cnt", 32'(dn), 32'd1);
        check_output("ones_busy", 32'(bb), 32'd0);
        check_output("ones_vec", 32'(vb), 32'd0);
        check_output("ones_table", 32'(tbl0), 32'hFFFF);
        check_output("ones_pass_done", 32'(pd), 32'h1);
        check_output("ones_pass_idle", 32'(pass0), 32'h1);

        // d buffer against EXPECTED=FFFF: table AAAA, no pass
        $display("[TB] sweep, s_in=d, EXPECTED=FFFF");
        s0_mode = 1;
        apply_stimulus(0, 0, 2, 49, dc, dn, bb, vb, pd, cb);
        check_output("dbuf_clear_at_start", 32'(cb), 32'd0);
        check_output("dbuf_table", 32'(tbl0), 32'hAAAA);
        check_output("dbuf_pass", 32'(pass0), 32'h0);
        check_output("dbuf_done_cyc", 32'(dc), 32'd49);

        // d buffer against EXPECTED=AAAA
        $display("[TB] sweep, s_in=d, EXPECTED=AAAA");
        apply_stimulus(1, 0, 2, 49, dc, dn, bb, vb, pd, cb);
        check_output("aaaa_table", 32'(tbl1), 32'hAAAA);
        check_output("aaaa_pass", 32'(pd), 32'h1);
        check_output("aaaa_done_cyc", 32'(dc), 32'd49);

        // Second start mid-sweep is ignored
        $display("[TB] start again at cycle 20");
        s0_mode = 0;
        apply_stimulus(0, 20, 2, 49, dc, dn, bb, vb, pd, cb);
        check_output("restart_done_cyc", 32'(dc), 32'd49);
        check_output("restart_done_cnt", 32'(dn), 32'd1);
        check_output("restart_busy", 32'(bb), 32'd0);
        check_output("restart_vec", 32'(vb), 32'd0);

        // Reset asserted at cycle 25 of a sweep
        $display("[TB] reset mid-sweep");
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (24) @(negedge clk);
        check_output("midrst_pre_table", 32'(tbl0), 32'h00FF);
        rst_n = 1'b0;
        #1;
        check_output("midrst_vec", 32'(vec0), 32'h0);
        check_output("midrst_busy", 32'(busy0), 32'h0);
        check_output("midrst_table", 32'(tbl0), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 60; i++) begin
            if (done0 === 1'b1) dn++;
            @(negedge clk);
        end
        check_output("midrst_no_done", 32'(dn), 32'd0);
        apply_stimulus(0, 0, 2, 49, dc, dn, bb, vb, pd, cb);
        check_output("postrst_done_cyc", 32'(dc), 32'd49);
        check_output("postrst_table", 32'(tbl0), 32'hFFFF);
        check_output("postrst_pass", 32'(pd), 32'h1);

        // One settle cycle per vector
        $display("[TB] SETTLE_CYCLES=1");
        apply_stimulus(2, 0, 1, 33, dc, dn, bb, vb, pd, cb);
        check_output("s1_done_cyc", 32'(dc), 32'd33);
        check_output("s1_busy", 32'(bb), 32'd0);
        check_output("s1_vec", 32'(vb), 32'd0);
        check_output("s1_table", 32'(tbl2), 32'hFFFF);
        check_output("s1_pass", 32'(pd), 32'h1);

`ifdef SWEEP_FAIL_CAPTURE_EN
        // Mismatches at vectors 5 and 9
        $display("[TB] fail capture");
        s0_mode = 2;
        apply_stimulus(0, 0, 2, 49, dc, dn, bb, vb, pd, cb);
        check_output("fc_table", 32'(tbl0), 32'hFDDF);
        check_output("fc_pass", 32'(pass0), 32'h0);
        check_output("fc_cnt", 32'(fc0), 32'd2);
        check_output("fc_first", 32'(ff0), 32'd5);
        check_output("fc_vld", 32'(fv0), 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
